// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: state encoding and default width.
package mult_pkg;

    localparam int WIDTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_array_row.sv
// One-bit full adder and the ripple add/subtract row used by the multiplier datapath.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    // Plain carry-propagate full adder cell.
    always_comb begin
        s    = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end
endmodule

// acc +/- (addend gated by gate); subtraction is invert-and-carry-in, all modulo 2^N.
module ArrayRow #(
    parameter int N = 6
) (
    input  logic [N-1:0] addend,
    input  logic         gate,
    input  logic [N-1:0] acc,
    input  logic         sub,
    output logic [N-1:0] sum
);
    logic [N-1:0] opnd;
    logic [N-1:0] carry;

    // Gate the partial product by the multiplier bit, then conditionally invert for subtract.
    always_comb begin
        opnd = (addend & {N{gate}}) ^ {N{sub}};
    end

    assign carry[0] = sub;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            if (i < N - 1) begin : g_fa
                full_adder u_fa (
                    .x   (acc[i]),
                    .y   (opnd[i]),
                    .cin (carry[i]),
                    .s   (sum[i]),
                    .cout(carry[i+1])
                );
            end else begin : g_msb
                // Carry out of the top bit is discarded (modulo arithmetic), so only the sum is formed.
                assign sum[i] = acc[i] ^ opnd[i] ^ carry[i];
            end
        end
    endgenerate
endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential two's-complement shift-add multiplier: one multiplier bit per cycle, sign bit subtracted.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    state_t                   state_q, state_d;
    logic signed [WIDTH-1:0]  a_q, a_d;
    logic signed [WIDTH-1:0]  b_q, b_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic signed [PW-1:0]     acc_q, acc_d;
    logic signed [PW-1:0]     prod_q, prod_d;

    logic [PW-1:0]            addend;
    logic [PW-1:0]            row_sum;
    logic                     last_step;
    logic                     accept;

    // Sign-extended multiplicand aligned to the weight of the current multiplier bit.
    always_comb begin
        addend    = {{WIDTH{a_q[WIDTH-1]}}, a_q} << cnt_q;
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    ArrayRow #(
        .N(PW)
    ) u_row (
        .addend(addend),
        .gate  (b_q[cnt_q]),
        .acc   (acc_q),
        .sub   (last_step),
        .sum   (row_sum)
    );

    // Next-state and datapath update; product only moves on the step that enters DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        accept  = start && (state_q != ST_RUN);
        case (state_q)
            ST_RUN: begin
                acc_d = row_sum;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = ST_DONE;
                    prod_d  = row_sum;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // All state, with asynchronous clear of every register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: WIDTH=3 and WIDTH=8 instances checked every cycle against a latency/product model.
module tb_seq_mult_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic              start3 = 1'b0;
    logic signed [2:0] a3 = '0, b3 = '0;
    logic              ready3, busy3, done3;
    logic signed [5:0] prod3;

    logic              start8 = 1'b0;
    logic signed [7:0] a8 = '0, b8 = '0;
    logic              ready8, busy8, done8;
    logic signed [15:0] prod8;

    int n_vec  = 0;
    int n_fail = 0;

    // Model per instance: cycles left in the operation, pending result, expected done and product.
    int W[2]    = '{3, 8};
    int rem[2]  = '{0, 0};
    int pend[2] = '{0, 0};
    int pexp[2] = '{0, 0};
    bit dexp[2] = '{1'b0, 1'b0};

    always #5 clock = ~clock;

    seq_mult_ctrl #(.WIDTH(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .start(start3), .a(a3), .b(b3),
        .ready(ready3), .busy(busy3), .done(done3), .product(prod3)
    );

    seq_mult_ctrl #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .product(prod8)
    );

    task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // An operation accepted when idle completes W cycles later with product a*b.
    task automatic step(input int i, input bit st, input int av, input int bv);
        bit acc;
        acc = st && (rem[i] == 0);
        if (rem[i] > 0) begin
            rem[i]  = rem[i] - 1;
            dexp[i] = (rem[i] == 0);
            if (dexp[i]) pexp[i] = pend[i];
        end else begin
            dexp[i] = 1'b0;
        end
        if (acc) begin
            rem[i]  = W[i];
            pend[i] = av * bv;
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                rem[i] = 0; pend[i] = 0; pexp[i] = 0; dexp[i] = 1'b0;
            end
        end else begin
            step(0, start3, a3, b3);
            step(1, start8, a8, b8);
        end
    end

    always @(negedge clock) begin
        chk("ready3", ready3, rem[0] == 0);
        chk("busy3",  busy3,  rem[0] > 0);
        chk("done3",  done3,  dexp[0]);
        chk("prod3",  prod3,  pexp[0]);
        chk("ready8", ready8, rem[1] == 0);
        chk("busy8",  busy8,  rem[1] > 0);
        chk("done8",  done8,  dexp[1]);
        chk("prod8",  prod8,  pexp[1]);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_done3(input string nm, input int expv);
        int k;
        k = 0;
        while (done3 !== 1'b1 && k < 20) begin cyc(1); k++; end
        chk({nm, "_done"}, done3, 1);
        chk(nm, prod3, expv);
    endtask

    task automatic op3(input int av, input int bv, input int expv, input string nm);
        int k;
        k = 0;
        while (ready3 !== 1'b1 && k < 20) begin cyc(1); k++; end
        a3 = 3'(av); b3 = 3'(bv); start3 = 1'b1;
        cyc(1);
        start3 = 1'b0;
        wait_done3(nm, expv);
    endtask

    initial begin
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        chk("rst_prod", prod3, 0);
        chk("rst_ready", ready3, 1);

        op3(3, 2, 6, "p_3x2");
        op3(-4, -4, 16, "p_m4xm4");
        op3(-4, 3, -12, "p_m4x3");
        op3(0, -1, 0, "p_0xm1");

        // Start pulsed mid-run with other operands must be ignored.
        a3 = 3'sd3; b3 = 3'sd2; start3 = 1'b1;
        cyc(1);
        start3 = 1'b0;
        cyc(1);
        a3 = -3'sd1; b3 = -3'sd1; start3 = 1'b1;
        cyc(1);
        start3 = 1'b0;
        wait_done3("p_ignore", 6);

        // Reset in the second run cycle abandons the operation and clears product.
        cyc(1);
        a3 = 3'sd2; b3 = 3'sd3; start3 = 1'b1;
        cyc(1);
        start3 = 1'b0;
        cyc(1);
        reset_n = 1'b0;
        #1;
        chk("midrst_prod", prod3, 0);
        chk("midrst_busy", busy3, 0);
        chk("midrst_ready", ready3, 1);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        op3(-1, -1, 1, "p_m1xm1");

        fork
            begin
                // Back-to-back with operands changing every cycle.
                start3 = 1'b1;
                repeat (40) begin
                    a3 = 3'($urandom); b3 = 3'($urandom);
                    cyc(1);
                end
                start3 = 1'b0;
                cyc(6);
                for (int x = -4; x < 4; x++)
                    for (int y = -4; y < 4; y++)
                        op3(x, y, x * y, "sweep3");
            end
            begin
                repeat (800) begin
                    start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
                    cyc(1);
                end
                start8 = 1'b0;
                for (int k = 0; k < 20 && ready8 !== 1'b1; k++) cyc(1);
                a8 = -8'sd128; b8 = -8'sd128; start8 = 1'b1;
                cyc(1);
                start8 = 1'b0;
                cyc(10);
                chk("p8_min_sq", prod8, 16384);
            end
        join

        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 3, operand width in bits (two's complement); legal range 2..16.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply; sampled on rising clock.
REQ-005 a  input  WIDTH  signed multiplicand; sampled only when start is accepted.
REQ-006 b  input  WIDTH  signed multiplier; sampled only when start is accepted.
REQ-007 ready  output  1  high when start will be accepted this cycle.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; product valid in that cycle.
REQ-010 product  output  2*WIDTH  signed result; held until the next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE; the state register, operand registers and a log2-sized iteration counter SHALL be the only sequential storage, plus the accumulator.
REQ-012 ready SHALL equal (state==IDLE or state==DONE); busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-013 Start accepted = start && ready at a rising edge: latch a and b, clear accumulator, counter := 0, state := RUN.
REQ-014 start while busy SHALL be ignored with no effect on operands, counter or result.
REQ-015 In RUN, each cycle SHALL process multiplier bit b[counter]: partial product = a AND b[counter], sign-extended to 2*WIDTH and shifted left by counter.
REQ-016 For counter < WIDTH-1 the partial product SHALL be added to the accumulator; for counter == WIDTH-1 it SHALL be subtracted (two's-complement sign-bit weight).
REQ-017 All accumulator arithmetic SHALL be modulo 2^(2*WIDTH); no overflow flag (result always representable, including (-2^(W-1))^2).
REQ-018 RUN SHALL last exactly WIDTH cycles; after the counter==WIDTH-1 step, state := DONE and product := final accumulator in the same edge.
REQ-019 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH; done high for exactly one cycle.
REQ-020 DONE SHALL return to IDLE next edge unless start is accepted in DONE, which SHALL go directly to RUN (back-to-back, one result per WIDTH+1 cycles).
REQ-021 product SHALL change only at the edge entering DONE; it SHALL not show intermediate accumulator values.

Reset
REQ-022 reset_n low SHALL immediately force state IDLE, counter 0, accumulator 0, product 0, operand registers 0.
REQ-023 Outputs during and after reset: ready=1, busy=0, done=0, product=0.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; first accepted start after release behaves as from power-up.

Structure
REQ-025 The FSM state encoding and the WIDTH default SHALL live in shared package mult_pkg.
REQ-026 One sub-module SHALL be instantiated: ArrayRow, a 2*WIDTH-bit combinational add/subtract row (gated partial product plus accumulator, subtract control), built from the team's one-bit full adder; the controller holds all sequencing.

Verification
REQ-027 WIDTH=3, reset, start with a=3, b=2 -> busy 3 cycles, done pulse in 4th cycle after acceptance, product=6 (000110).
REQ-028 a=-4, b=-4 -> product=16 (010000); a=-4, b=3 -> product=-12 (110100); a=0, b=-1 -> product=0.
REQ-029 start held high continuously with new operands each DONE -> results every 4 cycles, each matching a*b of operands present at acceptance; mid-RUN operand changes ignored.
REQ-030 start pulsed during RUN with different a,b -> ignored; product equals first operation's result.
REQ-031 reset_n asserted in 2nd RUN cycle -> immediate IDLE, product=0, no done; subsequent a=-1, b=-1 -> product=1.
REQ-032 Exhaustive WIDTH=3 sweep (64 pairs) and random WIDTH=8 -> product equals reference signed multiply for all cases.
